// File: rtl/dpram_bist_pkg.sv
// Shared types and helpers for the dual-port RAM march BIST.
// Holds the FSM encoding, the data pattern function and the tag width.
package dpram_bist_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StWrP   = 3'd1,
        StRdP   = 3'd2,
        StWrN   = 3'd3,
        StRdN   = 3'd4,
        StDrain = 3'd5,
        StDone  = 3'd6
    } state_e;

    // Tag carried through the read pipe is {expected data, address}.
    function automatic int unsigned tag_width(input int unsigned aw, input int unsigned dw);
        return aw + dw;
    endfunction

    // Callers zero-extend the address and truncate the result to DATA_WIDTH.
    function automatic logic [63:0] pattern(input logic [63:0] addr, input logic [63:0] seed);
        return addr ^ seed;
    endfunction

endpackage

// File: rtl/dpram_bist_checker.sv
// Read-tag pipe aligned to RAM read latency, plus compare, error count and
// first-failure capture.
module dpram_bist_checker
    import dpram_bist_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clear,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_expected,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_ram_rdata,
    output logic                  o_empty,
    output logic                  o_mismatch,
    output logic [ADDR_WIDTH+1:0] o_err_count,
    output logic [ADDR_WIDTH-1:0] o_fail_addr,
    output logic [DATA_WIDTH-1:0] o_fail_data
);

    localparam int unsigned TagW   = tag_width(ADDR_WIDTH, DATA_WIDTH);
    // Stage 0 lines up with the registered read strobe; the last stage lines
    // up with the cycle its read data is valid.
    localparam int unsigned Stages = RD_LATENCY + 1;

    logic [Stages-1:0] vld_q;
    logic [TagW-1:0]   tag_q [Stages];

    logic [DATA_WIDTH-1:0] exp_last;
    logic [ADDR_WIDTH-1:0] addr_last;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_q <= '0;
            for (int i = 0; i < int'(Stages); i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            vld_q    <= {vld_q[Stages-2:0], i_push};
            tag_q[0] <= {i_expected, i_addr};
            for (int i = 1; i < int'(Stages); i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    always_comb begin
        exp_last   = tag_q[Stages-1][TagW-1 -: DATA_WIDTH];
        addr_last  = tag_q[Stages-1][ADDR_WIDTH-1:0];
        o_mismatch = vld_q[Stages-1] && (i_ram_rdata != exp_last);
        // The last stage is compared this cycle, so only earlier ones matter.
        o_empty    = ~|vld_q[Stages-2:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            o_err_count <= '0;
            o_fail_addr <= '0;
            o_fail_data <= '0;
        end else if (o_mismatch) begin
            o_err_count <= o_err_count + 1'b1;
            if (o_err_count == '0) begin
                o_fail_addr <= addr_last;
                o_fail_data <= i_ram_rdata;
            end
        end
    end

endmodule

// File: rtl/dpram_bist.sv
// March BIST initiator for the dual-port RAM: write P, read P, write ~P,
// read ~P over every address, reporting pass/fail and first failure.
module dpram_bist
    import dpram_bist_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 4,
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           RD_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] PATTERN    = 8'hA5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_pass,
    output logic [ADDR_WIDTH-1:0] o_fail_addr,
    output logic [DATA_WIDTH-1:0] o_fail_data,
    output logic [ADDR_WIDTH+1:0] o_err_count,
    output logic                  o_ram_valid,
    output logic                  o_ram_cs,
    output logic                  o_ram_wr_en,
    output logic                  o_ram_rd_en,
    output logic [ADDR_WIDTH-1:0] o_ram_wraddr,
    output logic [ADDR_WIDTH-1:0] o_ram_raddr,
    output logic [DATA_WIDTH-1:0] o_ram_wdata,
    input  logic [DATA_WIDTH-1:0] i_ram_rdata,
    input  logic                  i_ram_ready
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  issue_wr, issue_rd, start_acc;
    logic [DATA_WIDTH-1:0] pat, access_data;
    logic                  chk_empty, chk_mismatch;

    always_comb begin
        pat         = DATA_WIDTH'(pattern(64'(addr_q), 64'(PATTERN)));
        access_data = ((state_q == StWrN) || (state_q == StRdN)) ? ~pat : pat;
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        issue_wr  = 1'b0;
        issue_rd  = 1'b0;
        start_acc = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d   = StWrP;
                    addr_d    = '0;
                    start_acc = 1'b1;
                end
            end
            StWrP, StRdP, StWrN, StRdN: begin
                if (i_ram_ready) begin
                    issue_wr = (state_q == StWrP) || (state_q == StWrN);
                    issue_rd = !issue_wr;
                    addr_d   = addr_q + 1'b1;
                    if (&addr_q) begin
                        unique case (state_q)
                            StWrP:   state_d = StRdP;
                            StRdP:   state_d = StWrN;
                            StWrN:   state_d = StRdN;
                            default: state_d = StDrain;
                        endcase
                    end
                end
            end
            StDrain: begin
                if (chk_empty) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_pass       <= 1'b0;
            o_ram_valid  <= 1'b0;
            o_ram_cs     <= 1'b0;
            o_ram_wr_en  <= 1'b0;
            o_ram_rd_en  <= 1'b0;
            o_ram_wraddr <= '0;
            o_ram_raddr  <= '0;
            o_ram_wdata  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            o_busy      <= (state_d != StIdle);
            o_done      <= (state_d == StDone);
            o_ram_valid <= issue_wr || issue_rd;
            o_ram_cs    <= issue_wr || issue_rd;
            o_ram_wr_en <= issue_wr;
            o_ram_rd_en <= issue_rd;
            if (issue_wr) begin
                o_ram_wraddr <= addr_q;
                o_ram_wdata  <= access_data;
            end
            if (issue_rd) begin
                o_ram_raddr <= addr_q;
            end
            // The compare resolving on the DONE edge still counts toward the verdict.
            if (start_acc) begin
                o_pass <= 1'b0;
            end else if (state_d == StDone) begin
                o_pass <= (o_err_count == '0) && !chk_mismatch;
            end
        end
    end

    dpram_bist_checker #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_checker (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clear     (start_acc),
        .i_push      (issue_rd),
        .i_expected  (access_data),
        .i_addr      (addr_q),
        .i_ram_rdata (i_ram_rdata),
        .o_empty     (chk_empty),
        .o_mismatch  (chk_mismatch),
        .o_err_count (o_err_count),
        .o_fail_addr (o_fail_addr),
        .o_fail_data (o_fail_data)
    );

endmodule

// File: tb/tb_dpram_bist.sv
// Directed bench for dpram_bist: table of march runs against a RAM model with
// injectable read faults, plus hand sequences for reset and restart cases.
module tb_dpram_bist;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy, done, pass;
    logic [3:0] fail_addr;
    logic [7:0] fail_data;
    logic [5:0] err_count;
    logic       ram_valid, ram_cs, ram_wr_en, ram_rd_en;
    logic [3:0] ram_wraddr, ram_raddr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic       ram_ready;

    always #5 clk = ~clk;

    dpram_bist #(
        .ADDR_WIDTH (4),
        .DATA_WIDTH (8),
        .RD_LATENCY (1),
        .PATTERN    (8'hA5)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .o_busy       (busy),
        .o_done       (done),
        .o_pass       (pass),
        .o_fail_addr  (fail_addr),
        .o_fail_data  (fail_data),
        .o_err_count  (err_count),
        .o_ram_valid  (ram_valid),
        .o_ram_cs     (ram_cs),
        .o_ram_wr_en  (ram_wr_en),
        .o_ram_rd_en  (ram_rd_en),
        .o_ram_wraddr (ram_wraddr),
        .o_ram_raddr  (ram_raddr),
        .o_ram_wdata  (ram_wdata),
        .i_ram_rdata  (ram_rdata),
        .i_ram_ready  (ram_ready)
    );

    // RAM model, read latency 1; faults: 1 = bit0 of addr 6 stuck-at-1, 2 = bit7 stuck-at-0.
    logic [7:0] mem [16];
    int         fault_mode = 0;

    always @(posedge clk) begin
        if (ram_valid && ram_cs && ram_wr_en) mem[ram_wraddr] <= ram_wdata;
        if (ram_valid && ram_cs && ram_rd_en) begin
            if (fault_mode == 1 && ram_raddr == 4'd6) ram_rdata <= mem[ram_raddr] | 8'h01;
            else if (fault_mode == 2)                 ram_rdata <= mem[ram_raddr] & 8'h7F;
            else                                      ram_rdata <= mem[ram_raddr];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one start-to-done pass, checking access order against the march model.
    task automatic run_once(input int stall, input int mid_start, output int done_cyc,
                            output int bad, output int n_acc,
                            output logic [7:0] wd4, output logic [7:0] wd36);
        int         a;
        logic       exp_wr;
        logic [7:0] p;
        done_cyc = -1;
        bad      = 0;
        n_acc    = 0;
        wd4      = 8'h00;
        wd36     = 8'h00;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (!busy) bad++;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (ram_valid || ram_cs || ram_wr_en || ram_rd_en) begin
                if (!(ram_valid && ram_cs) || (ram_wr_en == ram_rd_en)) bad++;
                if (stall != 0 && n >= 26 && n <= 28) bad++;
                if (n_acc >= 64) begin
                    bad++;
                end else begin
                    a      = n_acc % 16;
                    exp_wr = ((n_acc / 16) % 2) == 0;
                    p      = 8'hA5 ^ 8'(a);
                    if (n_acc >= 32) p = ~p;
                    if (ram_wr_en != exp_wr) bad++;
                    if (exp_wr) begin
                        if (ram_wraddr != 4'(a) || ram_wdata != p) bad++;
                    end else if (ram_raddr != 4'(a)) begin
                        bad++;
                    end
                    if (n_acc == 4)  wd4  = ram_wdata;
                    if (n_acc == 36) wd36 = ram_wdata;
                end
                n_acc++;
            end
            if (!busy) bad++;
            if (done) begin
                done_cyc = n;
                break;
            end
            start     = (mid_start != 0 && n == 40);
            ram_ready = !(stall != 0 && n >= 25 && n <= 27);
        end
        start     = 1'b0;
        ram_ready = 1'b1;
    endtask

    typedef struct {
        string      name;
        int         fault;
        int         stall;
        int         mid_start;
        int         exp_done;
        logic       exp_pass;
        int         exp_err;
        logic [3:0] exp_faddr;
        logic [7:0] exp_fdata;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int         dc, bad, nacc;
        logic [7:0] wd4, wd36;

        vecs[0] = '{"clean",     0, 0, 0, 66, 1'b1,  0, 4'd0, 8'h00};
        vecs[1] = '{"sa1_a6b0",  1, 0, 0, 66, 1'b0,  1, 4'd6, 8'h5D};
        vecs[2] = '{"sa0_b7",    2, 0, 0, 66, 1'b0, 16, 4'd0, 8'h25};
        vecs[3] = '{"stall3",    0, 1, 0, 69, 1'b1,  0, 4'd0, 8'h00};
        vecs[4] = '{"mid_start", 0, 0, 1, 66, 1'b1,  0, 4'd0, 8'h00};

        rst       = 1'b1;
        start     = 1'b0;
        ram_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pass", 32'(pass), 0);
        check("rst_err", 32'(err_count), 0);
        check("rst_strobes", 32'({ram_valid, ram_cs, ram_wr_en, ram_rd_en}), 0);
        check("rst_fail", 32'({fail_addr, fail_data}), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < 5; v++) begin
            fault_mode = vecs[v].fault;
            run_once(vecs[v].stall, vecs[v].mid_start, dc, bad, nacc, wd4, wd36);
            check({vecs[v].name, "_done_cycle"}, 32'(dc), 32'(vecs[v].exp_done));
            check({vecs[v].name, "_order"}, 32'(bad), 0);
            check({vecs[v].name, "_n_acc"}, 32'(nacc), 64);
            check({vecs[v].name, "_wdata4"}, 32'(wd4), 32'h A1);
            check({vecs[v].name, "_wdata4_inv"}, 32'(wd36), 32'h5E);
            check({vecs[v].name, "_pass"}, 32'(pass), 32'(vecs[v].exp_pass));
            check({vecs[v].name, "_err"}, 32'(err_count), 32'(vecs[v].exp_err));
            check({vecs[v].name, "_faddr"}, 32'(fail_addr), 32'(vecs[v].exp_faddr));
            check({vecs[v].name, "_fdata"}, 32'(fail_data), 32'(vecs[v].exp_fdata));
            @(posedge clk);
            #1;
            check({vecs[v].name, "_done_pulse"}, 32'(done), 0);
            check({vecs[v].name, "_idle"}, 32'(busy), 0);
            check({vecs[v].name, "_pass_held"}, 32'(pass), 32'(vecs[v].exp_pass));
        end

        // Reset mid-RD_P with errors already counted, then a clean rerun.
        fault_mode = 2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("pre_rst_err", 32'(err_count), 2);
        check("pre_rst_rd", 32'(ram_rd_en), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_strobes", 32'({ram_valid, ram_cs, ram_wr_en, ram_rd_en}), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_err", 32'(err_count), 0);
        check("midrst_fail", 32'({fail_addr, fail_data}), 0);
        check("midrst_pass", 32'(pass), 0);
        @(posedge clk);
        #1;
        fault_mode = 0;
        run_once(0, 0, dc, bad, nacc, wd4, wd36);
        check("rerun_done_cycle", 32'(dc), 66);
        check("rerun_order", 32'(bad), 0);
        check("rerun_pass", 32'(pass), 1);
        check("rerun_err", 32'(err_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
